interp_window_ctrl: RTL and testbench

Sequencer for the 15-row x 8-byte transposing window shift register that feeds the HEVC 8-tap sub-pixel filters. Given a block request, it fetches reference rows from the reference-sample memory in order and drives the shift register's load and flush. It flags each cycle in which the register output holds a complete, fresh 15-row window. The block sits between the reference-fetch memory port and the window shift register; the filter pipeline downstream accepts one window per cycle with no backpressure.

---
 rtl/interp_window_ctrl.sv | 174 +++++++++++++++++
 tb/tb_interp_window_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/interp_window_ctrl.sv
// Fetch sequencer for the 15-row x 8-byte transposing window shift register.
// Issues row reads, drives shift-register load/flush and flags complete windows.
module interp_window_ctrl #(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned ROWS_W    = 8,
    parameter int unsigned WIN_ROWS  = 15,
    parameter int unsigned MAX_OUTST = 2
) (
    input  logic              clock,
    input  logic              reset_L,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] row_stride,
    input  logic [ROWS_W-1:0] num_rows,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_gnt,
    input  logic              rd_valid,
    input  logic [63:0]       rd_data,
    output logic              sr_reset_L,
    output logic              sr_load_L,
    output logic [63:0]       sr_in,
    output logic              win_valid
);

    localparam int unsigned OUT_W = $clog2(MAX_OUTST + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        FETCH = 2'd2,
        DRAIN = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] stride_q, stride_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ROWS_W-1:0] rows_q, rows_d;
    logic [ROWS_W-1:0] issued_q, issued_d;
    logic [ROWS_W-1:0] loaded_q, loaded_d;
    logic [OUT_W-1:0]  outst_q, outst_d;
    logic              rd_req_q, rd_req_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              cfg_err_q, cfg_err_d;
    logic              win_pipe_q, win_pipe_d;
    logic              win_q, win_d;

    logic              start_ok;
    logic              accept;
    logic              beat;
    logic              last_win;

    assign start_ok = start & (num_rows >= ROWS_W'(WIN_ROWS));
    assign accept   = rd_req_q & rd_gnt;
    // Beats with nothing outstanding are stray and never reach the register.
    assign beat     = rd_valid & (outst_q != '0);
    assign last_win = (state_q == DRAIN) & win_q & ~win_pipe_q
                    & (loaded_q == rows_q) & (outst_q == '0);

    // State register
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_ok) state_d = FLUSH;
            FLUSH:   state_d = FETCH;
            FETCH:   if (issued_q == rows_q) state_d = DRAIN;
            DRAIN:   if (last_win) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        rows_d     = rows_q;
        stride_d   = stride_q;
        rd_addr_d  = rd_addr_q;
        issued_d   = issued_q;
        loaded_d   = loaded_q;
        outst_d    = outst_q;
        cfg_err_d  = 1'b0;
        done_d     = last_win;
        busy_d     = (state_d != IDLE);
        win_pipe_d = 1'b0;
        win_d      = win_pipe_q;
        rd_req_d   = 1'b0;
        sr_reset_L = reset_L & (state_q != FLUSH);
        sr_load_L  = ~beat;
        sr_in      = reset_L ? rd_data : '0;

        if ((state_q == IDLE) && start) begin
            if (start_ok) begin
                rows_d    = num_rows;
                stride_d  = row_stride;
                rd_addr_d = base_addr;
                issued_d  = '0;
                loaded_d  = '0;
            end else begin
                cfg_err_d = 1'b1;
            end
        end

        if (accept) begin
            rd_addr_d = rd_addr_q + stride_q;
            issued_d  = issued_q + ROWS_W'(1);
        end

        if (accept && !beat) begin
            outst_d = outst_q + OUT_W'(1);
        end else if (beat && !accept) begin
            outst_d = outst_q - OUT_W'(1);
        end

        // Window is complete once the 15th row has shifted in; output lags two edges.
        if (beat) begin
            loaded_d   = loaded_q + ROWS_W'(1);
            win_pipe_d = (loaded_q >= ROWS_W'(WIN_ROWS - 1));
        end

        rd_req_d = (state_d == FETCH) & (issued_d < rows_d)
                 & (outst_d < OUT_W'(MAX_OUTST));
    end

    // Registered datapath and outputs
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            rows_q     <= '0;
            stride_q   <= '0;
            rd_addr_q  <= '0;
            issued_q   <= '0;
            loaded_q   <= '0;
            outst_q    <= '0;
            rd_req_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
            win_pipe_q <= 1'b0;
            win_q      <= 1'b0;
        end else begin
            rows_q     <= rows_d;
            stride_q   <= stride_d;
            rd_addr_q  <= rd_addr_d;
            issued_q   <= issued_d;
            loaded_q   <= loaded_d;
            outst_q    <= outst_d;
            rd_req_q   <= rd_req_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cfg_err_q  <= cfg_err_d;
            win_pipe_q <= win_pipe_d;
            win_q      <= win_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign cfg_err   = cfg_err_q;
    assign rd_req    = rd_req_q;
    assign rd_addr   = rd_addr_q;
    assign win_valid = win_q;

endmodule

// File: tb/tb_interp_window_ctrl.sv
// Bench for interp_window_ctrl: memory responder plus a row/beat-counting
// model that predicts addresses, loads, windows, done and cfg_err each cycle.
module tb_interp_window_ctrl;

    logic        clock = 1'b0;
    logic        reset_L;
    logic        start;
    logic [15:0] base_addr;
    logic [15:0] row_stride;
    logic [7:0]  num_rows;
    logic        busy, done, cfg_err, rd_req;
    logic [15:0] rd_addr;
    logic        rd_gnt;
    logic        rd_valid;
    logic [63:0] rd_data;
    logic        sr_reset_L, sr_load_L;
    logic [63:0] sr_in;
    logic        win_valid;

    interp_window_ctrl dut (
        .clock      (clock),
        .reset_L    (reset_L),
        .start      (start),
        .base_addr  (base_addr),
        .row_stride (row_stride),
        .num_rows   (num_rows),
        .busy       (busy),
        .done       (done),
        .cfg_err    (cfg_err),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_gnt     (rd_gnt),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .sr_reset_L (sr_reset_L),
        .sr_load_L  (sr_load_L),
        .sr_in      (sr_in),
        .win_valid  (win_valid)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Model state: a block is a list of rows base + k*stride loaded in order.
    bit          m_active = 0;
    int          m_rows, m_issued, m_outst, m_loaded;
    logic [15:0] m_base, m_stride;
    int          start_cyc = -1, flush_cyc = -1, exp_done_cyc = -1, exp_cfg_cyc = -1;
    int          win_exp[$];
    logic [15:0] mem_q[$];
    bit          prev_stall = 0;
    logic [15:0] prev_addr;
    bit          inject_stray = 0;

    int          win_seen, load_seen, done_seen, cfg_seen, max_outst;
    logic [15:0] addr_log[$];

    function automatic logic [63:0] row_data(input logic [15:0] a);
        return {a, ~a, a ^ 16'h5A5A, a + 16'h0101};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Called mid-cycle with this cycle's inputs applied and outputs settled.
    task automatic check_cycle();
        bit          beat, acc, exp_win;
        logic [15:0] ea;
        beat = rd_valid && (m_outst != 0);
        acc  = rd_req && rd_gnt;

        chk("sr_load_L", sr_load_L, !beat);
        if (beat) begin
            ea = m_base + 16'(m_loaded) * m_stride;
            chk("sr_in", sr_in, row_data(ea));
            m_loaded++;
            load_seen++;
            if (m_loaded >= 15) win_exp.push_back(cyc + 2);
            if (m_loaded == m_rows) exp_done_cyc = cyc + 3;
        end

        exp_win = (win_exp.size() != 0) && (win_exp[0] == cyc);
        if (exp_win) void'(win_exp.pop_front());
        chk("win_valid", win_valid, exp_win);
        if (win_valid) win_seen++;

        chk("done", done, cyc == exp_done_cyc);
        if (done) done_seen++;
        chk("cfg_err", cfg_err, cyc == exp_cfg_cyc);
        if (cfg_err) cfg_seen++;
        chk("sr_reset_L", sr_reset_L, cyc != flush_cyc);

        if (m_active && cyc > start_cyc && cyc != exp_done_cyc) chk("busy_high", busy, 1);
        else if (!m_active) chk("busy_low", busy, 0);
        if (cyc == exp_done_cyc) m_active = 0;

        if (prev_stall) begin
            chk("rd_req_held", rd_req, 1);
            chk("rd_addr_held", rd_addr, prev_addr);
        end
        if (rd_req) chk("rd_req_allowed", m_active && m_issued < m_rows && m_outst < 2, 1);
        if (acc) begin
            ea = m_base + 16'(m_issued) * m_stride;
            chk("rd_addr", rd_addr, ea);
            addr_log.push_back(rd_addr);
            mem_q.push_back(rd_addr);
            m_issued++;
        end
        prev_stall = rd_req && !rd_gnt;
        prev_addr  = rd_addr;
        m_outst    = m_outst + int'(acc) - int'(beat);
        if (m_outst > max_outst) max_outst = m_outst;

        if (start && !m_active) begin
            if (num_rows >= 8'd15) begin
                m_active = 1; m_rows = int'(num_rows); m_base = base_addr; m_stride = row_stride;
                m_issued = 0; m_loaded = 0; start_cyc = cyc; flush_cyc = cyc + 1; exp_done_cyc = -1;
            end else begin
                exp_cfg_cyc = cyc + 1;
            end
        end
        cyc++;
    endtask

    task automatic tick();
        #1;
        check_cycle();
        @(negedge clock);
        start = 1'b0;
        if (mem_q.size() != 0) begin
            rd_valid = 1'b1;
            rd_data  = row_data(mem_q.pop_front());
        end else if (inject_stray) begin
            rd_valid = 1'b1;
            rd_data  = 64'hDEAD_BEEF_0BAD_F00D;
            inject_stray = 0;
        end else begin
            rd_valid = 1'b0;
            rd_data  = '0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"},       busy, 0);
        chk({tag, "_done"},       done, 0);
        chk({tag, "_cfg_err"},    cfg_err, 0);
        chk({tag, "_rd_req"},     rd_req, 0);
        chk({tag, "_rd_addr"},    rd_addr, 0);
        chk({tag, "_win_valid"},  win_valid, 0);
        chk({tag, "_sr_load_L"},  sr_load_L, 1);
        chk({tag, "_sr_in"},      sr_in, 0);
        chk({tag, "_sr_reset_L"}, sr_reset_L, 0);
    endtask

    task automatic run_block(input logic [15:0] base, input logic [15:0] stride, input logic [7:0] rows,
                             input int stall_at, input int restart_at, input string tag);
        int n;
        addr_log.delete();
        win_seen = 0; load_seen = 0; done_seen = 0; max_outst = 0;
        base_addr = base; row_stride = stride; num_rows = rows; rd_gnt = 1'b1; start = 1'b1;
        tick();
        n = 0;
        while (m_active && n < 300) begin
            if (n == stall_at)     rd_gnt = 1'b0;
            if (n == stall_at + 3) rd_gnt = 1'b1;
            if (n == restart_at) begin
                base_addr = 16'h7000; num_rows = 8'd20; start = 1'b1;
            end
            tick();
            n++;
        end
        rd_gnt = 1'b1;
        chk({tag, "_completed_in_budget"}, m_active, 0);
        chk({tag, "_win_count"},  win_seen, int'(rows) - 14);
        chk({tag, "_load_count"}, load_seen, int'(rows));
        chk({tag, "_req_count"},  addr_log.size(), int'(rows));
        chk({tag, "_done_count"}, done_seen, 1);
        chk({tag, "_max_outst_le2"}, max_outst <= 2, 1);
        repeat (2) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int n;
        reset_L = 1'b0; start = 1'b0; base_addr = '0; row_stride = '0; num_rows = '0;
        rd_gnt = 1'b1; rd_valid = 1'b0; rd_data = '0;
        @(negedge clock);
        #1;
        check_reset_outputs("por");
        @(negedge clock);
        reset_L = 1'b1;
        repeat (2) tick();

        // Basic block with hand-computed address endpoints.
        run_block(16'h0100, 16'h0040, 8'd16, -10, -10, "basic");
        chk("basic_addr_first", addr_log[0], 16'h0100);
        chk("basic_addr_second", addr_log[1], 16'h0140);
        chk("basic_addr_last", addr_log[15], 16'h04C0);

        // Grant held low for three cycles mid-block.
        run_block(16'h0800, 16'h0020, 8'd18, 6, -10, "stall");

        // Rejected configuration.
        addr_log.delete(); cfg_seen = 0;
        base_addr = 16'h0500; row_stride = 16'h0010; num_rows = 8'd14; start = 1'b1;
        tick();
        repeat (4) tick();
        chk("badcfg_pulses", cfg_seen, 1);
        chk("badcfg_no_req", addr_log.size(), 0);

        // Second start during FETCH must be ignored.
        run_block(16'h2000, 16'h0010, 8'd18, -10, 4, "restart");

        // Stray beat while idle must not load.
        load_seen = 0;
        inject_stray = 1;
        repeat (3) tick();
        chk("stray_no_load", load_seen, 0);

        // Reset in the middle of FETCH after five loads.
        addr_log.delete(); load_seen = 0; done_seen = 0;
        base_addr = 16'h0300; row_stride = 16'h0020; num_rows = 8'd20; start = 1'b1;
        tick();
        n = 0;
        while (load_seen < 5 && n < 100) begin
            tick();
            n++;
        end
        chk("midreset_reached_5_loads", load_seen, 5);
        reset_L = 1'b0;
        #1;
        check_reset_outputs("midreset");
        repeat (2) begin
            @(negedge clock);
            rd_valid = 1'b1; rd_data = row_data(16'h0400);
            cyc++;
            #1;
            check_reset_outputs("inreset");
        end
        @(negedge clock);
        cyc++;
        reset_L = 1'b1; rd_valid = 1'b1; rd_data = row_data(16'h0420);
        m_active = 0; m_outst = 0; m_issued = 0; m_loaded = 0;
        mem_q.delete(); win_exp.delete(); prev_stall = 0;
        exp_done_cyc = -1; flush_cyc = -1;
        load_seen = 0; done_seen = 0;
        repeat (3) tick();
        chk("postreset_late_beat_ignored", load_seen, 0);
        chk("postreset_no_done", done_seen, 0);

        // Address wrap at the top of the address space.
        run_block(16'hFFC0, 16'h0040, 8'd15, -10, -10, "wrap");
        chk("wrap_addr0", addr_log[0], 16'hFFC0);
        chk("wrap_addr1", addr_log[1], 16'h0000);
        chk("wrap_addr2", addr_log[2], 16'h0040);
        chk("wrap_win_single", win_seen, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
